// File: rtl/ann_pkg.sv
// Shared constants and types for the neuron accumulate / sigmoid lookup path.
package ann_pkg;

  localparam int          FRAC_W   = 10;
  localparam logic [15:0] ONE_Q    = 16'h0400;
  localparam logic [7:0]  ADDR_SAT = 8'hFF;
  localparam int          SAT_MAG  = 8 << 20;

  typedef enum logic [1:0] {
    ACC,
    ADDR,
    OUT
  } state_t;

endpackage

// File: rtl/sig_addr_gen.sv
// Converts the signed Q.20 accumulator into the sigmoid table's unsigned 4.4
// magnitude address plus a sign flag. Magnitudes of 8.0 and above (and the
// most negative accumulator value, which has no positive twin) saturate.
module sig_addr_gen #(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic                    neg,
  output logic [7:0]              addr
);

  import ann_pkg::*;

  localparam logic [ACC_W-1:0] MAX_NEG = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] SAT_LIM = ACC_W'(SAT_MAG);

  logic [ACC_W-1:0] mag;
  logic             saturated;

  // Absolute value, saturation test and truncation of the fraction below 1/16.
  always_comb begin
    neg       = acc[ACC_W-1];
    mag       = neg ? $unsigned(-acc) : $unsigned(acc);
    saturated = ($unsigned(acc) == MAX_NEG) || (mag >= SAT_LIM);
    addr      = saturated ? ADDR_SAT : mag[23:16];
  end

endmodule

// File: rtl/neuron_mac_sig.sv
// Neuron stage: accumulates bias + sum(x*w) over a packet, addresses an
// external sigmoid table with |sum|, and mirrors the table value for negative
// sums to produce one activation per packet on a valid/ready output.
module neuron_mac_sig #(
  parameter int ACC_W  = 40,
  parameter int FRAC_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] s_x,
  input  logic signed [15:0] s_w,
  input  logic               s_last,
  input  logic signed [15:0] bias,
  output logic [7:0]         lut_addr,
  input  logic [15:0]        lut_sig,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [15:0]        m_y
);

  import ann_pkg::*;

  state_t                  state;
  state_t                  state_next;
  logic signed [ACC_W-1:0] acc;
  logic                    first;
  logic                    neg;
  logic                    addr_neg;
  logic [7:0]              addr_comb;
  logic                    beat;
  logic                    out_done;
  logic signed [31:0]      x_ext;
  logic signed [31:0]      w_ext;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_sum;

  assign beat     = s_valid && s_ready;
  assign out_done = (state == OUT) && m_valid && m_ready;

  sig_addr_gen #(
    .ACC_W(ACC_W)
  ) u_addr_gen (
    .acc (acc),
    .neg (addr_neg),
    .addr(addr_comb)
  );

  // Multiply-accumulate arithmetic; the bias seeds the sum on a packet's first beat.
  always_comb begin
    x_ext   = 32'(s_x);
    w_ext   = 32'(s_w);
    prod    = x_ext * w_ext;
    base    = first ? (ACC_W'(bias) <<< FRAC_W) : acc;
    acc_sum = base + ACC_W'(prod);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  // Next-state logic: accumulate until the last beat, one address cycle, then hold the result.
  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (beat && s_last) state_next = ADDR;
      ADDR:    state_next = OUT;
      OUT:     if (m_valid && m_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // Input side only accepts beats while accumulating and never while in reset.
  always_comb begin
    s_ready = (state == ACC) && !rst;
  end

  // Accumulator and first-beat flag; cleared once the activation is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      first <= 1'b1;
    end else if (beat) begin
      acc   <= acc_sum;
      first <= 1'b0;
    end else if (out_done) begin
      acc   <= '0;
      first <= 1'b1;
    end
  end

  // Table address and sign are captured in the address cycle and held through output.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg      <= 1'b0;
      lut_addr <= 8'h00;
    end else if (state == ADDR) begin
      neg      <= addr_neg;
      lut_addr <= addr_comb;
    end
  end

  // Result capture once the table output has settled, then hold until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_y     <= 16'h0000;
      m_valid <= 1'b0;
    end else if (state == OUT) begin
      if (!m_valid) begin
        m_y     <= neg ? (ONE_Q - lut_sig) : lut_sig;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_sig.sv
// Self-checking bench for neuron_mac_sig: directed cases plus random packets
// checked against an arithmetic reference using a real-valued sigmoid table.
module tb_neuron_mac_sig;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_x;
  logic signed [15:0] s_w;
  logic               s_last;
  logic signed [15:0] bias;
  logic [7:0]         lut_addr;
  logic [15:0]        lut_sig;
  logic               m_valid;
  logic               m_ready;
  logic [15:0]        m_y;

  logic [15:0] lut_mem [256];
  int          checks_total;
  int          checks_passed;

  neuron_mac_sig #(
    .ACC_W (40),
    .FRAC_W(10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_x     (s_x),
    .s_w     (s_w),
    .s_last  (s_last),
    .bias    (bias),
    .lut_addr(lut_addr),
    .lut_sig (lut_sig),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_y     (m_y)
  );

  assign lut_sig = lut_mem[lut_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_total++;
    assert (obs === exp_v) checks_passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  // Offer one beat and hold it for one rising edge; returns just after that edge.
  task automatic applyStimulus(input int xv, input int wv, input logic last, input int bv);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("beat_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_x     = 16'(xv);
    s_w     = 16'(wv);
    s_last  = last;
    bias    = 16'(bv);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called just after the last beat's edge: checks latency, address and result,
  // optionally stalls while offering an unwanted beat, then takes the result.
  task automatic awaitResult(input string tag, input logic [7:0] exp_addr,
                             input logic [15:0] exp_y, input int stall);
    int lat;
    lat = 0;
    @(negedge clk);
    while (m_valid !== 1'b1 && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd2);
    checkOutput({tag, "_addr"}, 32'(lut_addr), 32'(exp_addr));
    checkOutput({tag, "_y"}, 32'(m_y), 32'(exp_y));
    for (int i = 0; i < stall; i++) begin
      s_valid = 1'b1;
      s_x     = 16'sh2000;
      s_w     = 16'sh2000;
      s_last  = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_stall_y"}, 32'(m_y), 32'(exp_y));
      checkOutput({tag, "_stall_ready"}, 32'(s_ready), 32'd0);
      checkOutput({tag, "_stall_valid"}, 32'(m_valid), 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ready_back"}, 32'(s_ready), 32'd1);
    checkOutput({tag, "_valid_drop"}, 32'(m_valid), 32'd0);
  endtask

  // Reference: exact sum, magnitude to 4.4 address with saturation at 8.0, mirror if negative.
  function automatic void modelPacket(input longint sum, output logic [7:0] a, output logic [15:0] y);
    longint mag;
    int     t;
    mag = (sum < 0) ? -sum : sum;
    if (mag >= (longint'(8) * 1048576)) a = 8'hFF;
    else                                a = 8'(mag / 65536);
    t = int'(lut_mem[a]);
    y = (sum < 0) ? 16'(1024 - t) : 16'(t);
  endfunction

  initial begin
    real         v;
    int          t;
    int          nb;
    int          xv;
    int          wv;
    int          bv;
    longint      sum;
    logic [7:0]  ea;
    logic [15:0] ey;

    checks_total  = 0;
    checks_passed = 0;
    for (int i = 0; i < 256; i++) begin
      v = 1024.0 / (1.0 + $exp(-$itor(i) / 16.0));
      t = $rtoi($floor(v));
      if (t > 1023) t = 1023;
      lut_mem[i] = 16'(t);
    end

    rst     = 1'b1;
    s_valid = 1'b0;
    s_x     = '0;
    s_w     = '0;
    s_last  = 1'b0;
    bias    = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_y", 32'(m_y), 32'd0);
    checkOutput("rst_lut_addr", 32'(lut_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(s_ready), 32'd1);

    $display("[TB] positive lookup and symmetry");
    applyStimulus(16'h0400, 16'h0400, 1'b1, 0);
    awaitResult("pos_one", 8'h10, 16'h02EC, 0);
    applyStimulus(-1024, 16'h0400, 1'b1, 0);
    awaitResult("neg_one", 8'h10, 16'h0114, 0);
    applyStimulus(0, 0, 1'b1, 0);
    awaitResult("zero", 8'h00, 16'h0200, 0);

    $display("[TB] saturation");
    applyStimulus(16'h2800, 16'h0400, 1'b1, 0);
    awaitResult("sat_pos", 8'hFF, 16'h03FF, 0);
    applyStimulus(-10240, 16'h0400, 1'b1, 0);
    awaitResult("sat_neg", 8'hFF, 16'h0001, 0);

    $display("[TB] bias with multi-beat packet");
    applyStimulus(16'h0200, 16'h0400, 1'b0, 16'h0400);
    applyStimulus(-512, 16'h0400, 1'b1, 16'h7FFF);
    awaitResult("bias_multi", 8'h10, 16'h02EC, 0);

    $display("[TB] backpressure");
    applyStimulus(16'h0400, 16'h0400, 1'b1, 0);
    awaitResult("stall", 8'h10, 16'h02EC, 5);
    applyStimulus(0, 0, 1'b1, 0);
    awaitResult("after_stall", 8'h00, 16'h0200, 0);

    $display("[TB] reset mid-packet");
    applyStimulus(16'h2800, 16'h0400, 1'b1, 0);
    awaitResult("pre_rst", 8'hFF, 16'h03FF, 0);
    applyStimulus(16'h0400, 16'h0400, 1'b0, 0);
    applyStimulus(16'h0400, 16'h0400, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("midrst_m_y", 32'(m_y), 32'd0);
    checkOutput("midrst_lut_addr", 32'(lut_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, 0, 1'b1, 0);
    awaitResult("midrst_fresh", 8'h00, 16'h0200, 0);

    $display("[TB] random packets");
    for (int p = 0; p < 40; p++) begin
      nb  = int'($urandom_range(1, 5));
      bv  = int'($urandom_range(0, 4095)) - 2048;
      sum = longint'(bv) * 1024;
      for (int b = 0; b < nb; b++) begin
        xv  = int'($urandom_range(0, 4095)) - 2048;
        wv  = int'($urandom_range(0, 4095)) - 2048;
        sum = sum + longint'(xv) * longint'(wv);
        applyStimulus(xv, wv, (b == nb - 1), (b == 0) ? bv : int'($urandom_range(0, 65535)));
      end
      modelPacket(sum, ea, ey);
      awaitResult("rand", ea, ey, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
